raster_scan_ctrl: RTL

RASTER_SCAN_CTRL -- requirements
Module: raster_scan_ctrl

---
 rtl/defines_package.sv | 21 ++
 rtl/raster_scan_ctrl_pkg.sv | 10 +
 rtl/raster_scan_ctrl_bbox_clamp.sv | 24 ++
 rtl/raster_scan_ctrl.sv | 70 +++++++
 4 files changed

// File: rtl/defines_package.sv
// defines_package: shared geometry types, screen constants and small helpers
package defines_package;
  localparam int WIDTH = 640;
  localparam int HEIGHT = 480;
  localparam int WIREFRAME_ADDR_SIZE = 19;
  typedef struct packed {
    shortint x;
    shortint y;
  } Point2D;
  typedef struct packed {
    Point2D p;
    Point2D q;
    Point2D r;
  } Triangle2D;
  function automatic shortint min3(input shortint a, input shortint b, input shortint c);
    min3 = a < b ? (a < c ? a : c) : (b < c ? b : c);
  endfunction
  function automatic shortint max3(input shortint a, input shortint b, input shortint c);
    max3 = a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/raster_scan_ctrl_pkg.sv
// raster_scan_ctrl_pkg: bounding-box type and scan state encoding
package raster_scan_ctrl_pkg;
  typedef struct packed {
    shortint xmin;
    shortint xmax;
    shortint ymin;
    shortint ymax;
  } BBox;
  typedef enum logic [1:0] {IDLE, BBOX, SCAN} scan_state_t;
endpackage

// File: rtl/raster_scan_ctrl_bbox_clamp.sv
// bbox_clamp: screen-clamped bounding box of a triangle, flags empty boxes
module bbox_clamp
  import defines_package::*, raster_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480
) (
  input  Triangle2D tri_in,
  output BBox       box,
  output logic      empty
);
  shortint lo_x, hi_x, lo_y, hi_y;
  always_comb begin
    lo_x = min3(tri_in.p.x, tri_in.q.x, tri_in.r.x);
    hi_x = max3(tri_in.p.x, tri_in.q.x, tri_in.r.x);
    lo_y = min3(tri_in.p.y, tri_in.q.y, tri_in.r.y);
    hi_y = max3(tri_in.p.y, tri_in.q.y, tri_in.r.y);
    box.xmin = lo_x < 0 ? '0 : lo_x;
    box.xmax = hi_x > shortint'(WIDTH - 1) ? shortint'(WIDTH - 1) : hi_x;
    box.ymin = lo_y < 0 ? '0 : lo_y;
    box.ymax = hi_y > shortint'(HEIGHT - 1) ? shortint'(HEIGHT - 1) : hi_y;
    empty = box.xmin > box.xmax || box.ymin > box.ymax;
  end
endmodule

// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: walks a triangle's clamped bounding box in raster order, emitting pixel addresses
module raster_scan_ctrl
  import defines_package::*, raster_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  Triangle2D         tri_in,
  input  logic              tri_valid,
  output logic              tri_ready,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              tri_done,
  input  logic              flush,
  output logic              busy
);
  scan_state_t state_q, state_d;
  Triangle2D tri_q;
  BBox box, box_q;
  logic empty, done_q, fire, end_x;
  logic [ADDR_W-1:0] row_base;
  bbox_clamp #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_bbox (.tri_in(tri_q), .box(box), .empty(empty));
  assign tri_ready = state_q == IDLE;
  assign busy = !tri_ready;
  assign pix_valid = state_q == SCAN;
  assign end_x = pix_x == 16'(box_q.xmax);
  assign pix_last = pix_valid && end_x && pix_y == 16'(box_q.ymax);
  assign fire = pix_valid && pix_ready;
  assign tri_done = done_q || (state_q == BBOX && empty && !flush);
  assign pix_addr = row_base + ADDR_W'(pix_x);
  always_comb begin
    state_d = state_q == IDLE ? (tri_valid ? BBOX : IDLE)
            : flush ? IDLE
            : state_q == BBOX ? (empty ? IDLE : SCAN)
            : (fire && pix_last) ? IDLE : SCAN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      tri_q <= '0;
      box_q <= '0;
      pix_x <= '0;
      pix_y <= '0;
      row_base <= '0;
    end else begin
      state_q <= state_d;
      done_q <= fire && pix_last && !flush;
      if (tri_valid && tri_ready) tri_q <= tri_in;
      // the only multiply: row start of the first scanline
      if (state_q == BBOX && !empty) begin
        box_q <= box;
        pix_x <= 16'(box.xmin);
        pix_y <= 16'(box.ymin);
        row_base <= ADDR_W'(int'(box.ymin) * WIDTH);
      end else if (fire) begin
        pix_x <= end_x ? 16'(box_q.xmin) : pix_x + 16'd1;
        pix_y <= end_x ? pix_y + 16'd1 : pix_y;
        row_base <= end_x ? row_base + ADDR_W'(WIDTH) : row_base;
      end
    end
  end
endmodule
